led_pattern_seq: RTL and testbench

- Pattern sequencer for the running-light path. Replaces the free-running 3-bit counter that feeds the 3-8 LED decoder.
- Clocked by the divided 1 Hz clock clk1h. Produces the decoder select index idx.
- Supports up, down, bounce and hold patterns, a programmable advance rate, single-step while disabled, and a lap counter for status display.

---
 rtl/led_pattern_seq.sv | 184 ++++++++++++++++++
 tb/tb_led_pattern_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// Running-light pattern sequencer: drives the LED decoder select index with
// up/down/bounce/hold patterns, a programmable advance rate and a lap counter.
module led_pattern_seq #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned RATE_W = 4,
  parameter int unsigned LAP_W  = 8
) (
  input  logic              clk1h,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [RATE_W-1:0] rate,
  input  logic              step,
  output logic [IDX_W-1:0]  idx,
  output logic              dir,
  output logic              wrap,
  output logic [LAP_W-1:0]  lap_cnt
);

  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [LAP_W-1:0] LAP_MAX = {LAP_W{1'b1}};

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               dir_q, dir_d;
  logic               wrap_q, wrap_d;
  logic [LAP_W-1:0]   lap_cnt_q, lap_cnt_d;
  logic [RATE_W-1:0]  div_cnt_q, div_cnt_d;
  logic               step_dly_q, step_dly_d;

  logic [IDX_W-1:0]   adv_idx_c;
  logic               adv_dir_c;
  logic               adv_wrap_c;
  logic               do_adv_c;

  // Next position if an advance happens this tick, per the current mode.
  always_comb begin
    adv_idx_c  = idx_q;
    adv_dir_c  = dir_q;
    adv_wrap_c = 1'b0;
    case (mode)
      MODE_UP: begin
        adv_idx_c  = idx_q + IDX_ONE;
        adv_dir_c  = 1'b0;
        adv_wrap_c = (idx_q == IDX_MAX);
      end
      MODE_DOWN: begin
        adv_idx_c  = idx_q - IDX_ONE;
        adv_dir_c  = 1'b1;
        adv_wrap_c = (idx_q == '0);
      end
      MODE_BOUNCE: begin
        if (!dir_q) begin
          if (idx_q == IDX_MAX) begin
            adv_idx_c = IDX_MAX - IDX_ONE;
            adv_dir_c = 1'b1;
          end else begin
            adv_idx_c = idx_q + IDX_ONE;
          end
        end else begin
          if (idx_q == '0) begin
            adv_idx_c = IDX_ONE;
            adv_dir_c = 1'b0;
          end else begin
            adv_idx_c  = idx_q - IDX_ONE;
            // A bounce lap closes when the descending sweep lands on 0.
            adv_wrap_c = (idx_q == IDX_ONE);
          end
        end
      end
      MODE_HOLD: begin
        adv_idx_c  = idx_q;
        adv_dir_c  = dir_q;
        adv_wrap_c = 1'b0;
      end
      default: begin
        adv_idx_c  = idx_q;
        adv_dir_c  = dir_q;
        adv_wrap_c = 1'b0;
      end
    endcase
  end

  // Sequencing state machine: next state, prescaler and advance decision.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    step_dly_d = step;
    do_adv_c   = 1'b0;

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (step && !step_dly_q) begin
          do_adv_c = 1'b1;
        end
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // >= so that lowering rate mid-count advances on the next tick.
        if (div_cnt_q >= rate) begin
          do_adv_c  = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = RATE_W'(div_cnt_q + RATE_W'(1));
        end
        if (!en) begin
          state_d = IDLE;
        end else if (mode == MODE_HOLD) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!en) begin
          state_d = IDLE;
        end else if (mode != MODE_HOLD) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = '0;
      end
    endcase
  end

  // Position, pulse and lap bookkeeping driven by the advance decision.
  always_comb begin
    idx_d     = idx_q;
    dir_d     = dir_q;
    wrap_d    = 1'b0;
    lap_cnt_d = lap_cnt_q;

    if (do_adv_c) begin
      idx_d  = adv_idx_c;
      dir_d  = adv_dir_c;
      wrap_d = adv_wrap_c;
    end

    if (wrap_d && (lap_cnt_q != LAP_MAX)) begin
      lap_cnt_d = LAP_W'(lap_cnt_q + LAP_W'(1));
    end
  end

  always_ff @(posedge clk1h or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      lap_cnt_q  <= '0;
      div_cnt_q  <= '0;
      step_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      lap_cnt_q  <= lap_cnt_d;
      div_cnt_q  <= div_cnt_d;
      step_dly_q <= step_dly_d;
    end
  end

  assign idx     = idx_q;
  assign dir     = dir_q;
  assign wrap    = wrap_q;
  assign lap_cnt = lap_cnt_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: up/down/bounce/hold patterns, rate,
// single-step, lap saturation and asynchronous reset.
module tb_led_pattern_seq;

  logic       clk1h;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] rate;
  logic       step;
  logic [2:0] idx;
  logic       dir;
  logic       wrap;
  logic [7:0] lap_cnt;

  int checks;
  int failures;

  led_pattern_seq #(.IDX_W(3), .RATE_W(4), .LAP_W(8)) dut (
    .clk1h   (clk1h),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .rate    (rate),
    .step    (step),
    .idx     (idx),
    .dir     (dir),
    .wrap    (wrap),
    .lap_cnt (lap_cnt)
  );

  initial clk1h = 1'b0;
  always #5 clk1h = ~clk1h;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1h);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  int e_idx;
  int e_dir;
  int bnc_idx [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int bnc_dir [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int wrap_seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b0;
    en   = 1'b0;
    mode = 2'b00;
    rate = 4'd0;
    step = 1'b0;
    #3;
    check_val("rst_idx", int'(idx), 0);
    check_val("rst_dir", int'(dir), 0);
    check_val("rst_wrap", int'(wrap), 0);
    check_val("rst_lap", int'(lap_cnt), 0);
    rst = 1'b1;

    // Up pattern, advance every tick.
    tick(1);
    en = 1'b1;
    tick(1);
    check_val("up_enter_idx", int'(idx), 0);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check_val("up_idx", int'(idx), i % 8);
      check_val("up_wrap", int'(wrap), (i == 8) ? 1 : 0);
    end
    check_val("up_lap", int'(lap_cnt), 1);
    check_val("up_dir", int'(dir), 0);
    tick(1);
    check_val("up_wrap_one_cycle", int'(wrap), 0);

    // Down pattern, rate=2: three ticks per advance.
    do_reset();
    mode = 2'b01;
    rate = 4'd2;
    tick(1);
    e_idx = 0;
    e_dir = 0;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      if (k % 3 == 0) begin
        check_val("dn_wrap", int'(wrap), (e_idx == 0) ? 1 : 0);
        e_idx = (e_idx + 7) % 8;
        e_dir = 1;
      end else begin
        check_val("dn_wrap_idle", int'(wrap), 0);
      end
      check_val("dn_idx", int'(idx), e_idx);
      check_val("dn_dir", int'(dir), e_dir);
    end
    check_val("dn_lap", int'(lap_cnt), 1);

    // Bounce pattern, one full round trip and a bit.
    do_reset();
    mode = 2'b10;
    rate = 4'd0;
    tick(1);
    wrap_seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      check_val("bnc_idx", int'(idx), bnc_idx[i]);
      check_val("bnc_dir", int'(dir), bnc_dir[i]);
      check_val("bnc_wrap", int'(wrap), (i == 13) ? 1 : 0);
    end
    check_val("bnc_lap", int'(lap_cnt), 1);

    // Hold freezes idx and prescale phase.
    do_reset();
    mode = 2'b00;
    rate = 4'd2;
    tick(1);
    tick(10);
    check_val("hold_pre_idx", int'(idx), 3);
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_val("hold_idx", int'(idx), 3);
      check_val("hold_wrap", int'(wrap), 0);
    end
    mode = 2'b00;
    tick(1);
    check_val("hold_resume0", int'(idx), 3);
    tick(1);
    check_val("hold_resume1", int'(idx), 4);

    // Lowering rate mid-count advances on the next tick; rate=15 is 16 ticks.
    do_reset();
    mode = 2'b00;
    rate = 4'd15;
    tick(1);
    tick(5);
    check_val("rate_wait_idx", int'(idx), 0);
    rate = 4'd2;
    tick(1);
    check_val("rate_lower_idx", int'(idx), 1);
    rate = 4'd15;
    tick(15);
    check_val("rate_max_15", int'(idx), 1);
    tick(1);
    check_val("rate_max_16", int'(idx), 2);

    // Single-step while disabled: one advance per rising edge of step.
    do_reset();
    en   = 1'b0;
    mode = 2'b00;
    rate = 4'd0;
    tick(1);
    step = 1'b1;
    tick(1);
    check_val("step_first", int'(idx), 1);
    tick(2);
    check_val("step_held", int'(idx), 1);
    step = 1'b0;
    tick(1);
    check_val("step_low", int'(idx), 1);
    step = 1'b1;
    tick(1);
    check_val("step_second", int'(idx), 2);
    tick(1);
    check_val("step_second_held", int'(idx), 2);
    step = 1'b0;
    mode = 2'b11;
    tick(1);
    step = 1'b1;
    tick(1);
    check_val("step_hold_idx", int'(idx), 2);
    check_val("step_hold_wrap", int'(wrap), 0);
    step = 1'b0;

    // Lap counter saturation, then asynchronous reset mid-lap.
    do_reset();
    en   = 1'b1;
    mode = 2'b00;
    rate = 4'd0;
    tick(1);
    tick(255 * 8);
    check_val("lap_255", int'(lap_cnt), 255);
    check_val("lap_255_wrap", int'(wrap), 1);
    tick(8);
    check_val("lap_sat_wrap", int'(wrap), 1);
    check_val("lap_sat", int'(lap_cnt), 255);
    tick(5);
    check_val("pre_rst_idx", int'(idx), 5);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst_idx", int'(idx), 0);
    check_val("async_rst_lap", int'(lap_cnt), 0);
    check_val("async_rst_wrap", int'(wrap), 0);
    rst = 1'b1;
    tick(1);
    check_val("post_rst_idle_idx", int'(idx), 0);
    tick(1);
    check_val("post_rst_run_idx", int'(idx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
